cic_decim_comb: RTL and testbench

- Downstream stage of the 6-stage CIC integrator section in the N=6, R=128 decimator.
- Consumes the integrator output every clock and decimates by R using an internal phase counter.
- Runs N pipelined comb (differentiator) stages, differential delay M=1, at the decimated rate.
- Emits one full-precision output word plus a single-cycle valid pulse per R input clocks.

---
 rtl/cic_decim_comb_pkg.sv | 10 +
 rtl/cic_decim_comb_if.sv | 15 +
 rtl/cic_comb_stage.sv | 31 +++
 rtl/cic_decim_comb.sv | 88 ++++++++
 tb/tb_cic_decim_comb.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cic_decim_comb_pkg.sv
// Shared CIC constants and word type, common to the integrator and comb sections.
package cic_pkg;
  localparam int CIC_W     = 44;
  localparam int CIC_N     = 6;
  localparam int CIC_R     = 128;
  localparam int CIC_LOG2R = 7;
  localparam int CIC_OUT_W = 16;

  typedef logic signed [CIC_W-1:0] cic_word_t;
endpackage

// File: rtl/cic_decim_comb_if.sv
// Stream between the integrator section and the comb section.
// Handshake: no ready. Intin carries one sample every clk. Dout is valid only
// in the single cycle where Dvalid=1, and it holds its value between pulses.
interface cic_decim_comb_if
  import cic_pkg::*;
#(
  parameter int W = CIC_W
);
  logic signed [W-1:0] Intin;
  logic signed [W-1:0] Dout;
  logic                Dvalid;

  modport master (output Intin, input Dout, input Dvalid);
  modport slave  (input Intin, output Dout, output Dvalid);
endinterface

// File: rtl/cic_comb_stage.sv
// One comb (differentiator) stage with differential delay 1.
// Its registers move only when a decimated sample arrives.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = CIC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] din,
  output logic                out_valid,
  output logic signed [W-1:0] dout
);
  logic signed [W-1:0] z;

  // Subtraction wraps modulo 2^W, which the CIC needs for exact results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      z         <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dout <= din - z;
        z    <= din;
      end
    end
  end
endmodule

// File: rtl/cic_decim_comb.sv
// CIC decimator comb section: decimate by R, then N pipelined comb stages.
// Optional macro CIC_ROUND_EN adds a round-half-up output stage keeping OUT_W bits.
module cic_decim_comb
  import cic_pkg::*;
#(
  parameter int W     = CIC_W,
  parameter int N     = CIC_N,
  parameter int R     = CIC_R,
  parameter int OUT_W = CIC_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  cic_decim_comb_if.slave  bus
);
  localparam int            CW       = $clog2(R);
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  if (R < N + 3) begin : g_bad_r
    $error("cic_decim_comb: R must be at least N+3");
  end
  if (OUT_W < 2 || OUT_W >= W) begin : g_bad_out_w
    $error("cic_decim_comb: OUT_W must satisfy 2 <= OUT_W < W");
  end

  logic [CW-1:0]       cnt;
  logic signed [W-1:0] c0_q;
  logic                v0_q;
  logic signed [W-1:0] c [0:N];
  logic [N:0]          v;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      c0_q <= '0;
      v0_q <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      v0_q <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) begin
        c0_q <= bus.Intin;
      end
    end
  end

  assign c[0] = c0_q;
  assign v[0] = v0_q;

  for (genvar i = 1; i <= N; i++) begin : g_comb
    cic_comb_stage #(.W(W)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v[i-1]),
      .din       (c[i-1]),
      .out_valid (v[i]),
      .dout      (c[i])
    );
  end

`ifdef CIC_ROUND_EN
  localparam int                  SH   = W - OUT_W;
  localparam logic signed [W-1:0] HALF = W'(1) << (SH - 1);

  logic signed [W-1:0] rnd_sum;
  logic signed [W-1:0] dout_q;
  logic                dvalid_q;

  // The half-LSB add wraps like every other add; >>> sign-extends back to W.
  assign rnd_sum = c[N] + HALF;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= v[N];
      if (v[N]) begin
        dout_q <= rnd_sum >>> SH;
      end
    end
  end

  assign bus.Dout   = dout_q;
  assign bus.Dvalid = dvalid_q;
`else
  assign bus.Dout   = c[N];
  assign bus.Dvalid = v[N];
`endif
endmodule

// File: tb/tb_cic_decim_comb.sv
// Directed bench for cic_decim_comb: reset, pulse timing, comb transient, full CIC, mid-run reset.
module tb_cic_decim_comb;
  import cic_pkg::*;

  localparam int W = CIC_W;
  localparam int N = CIC_N;
  localparam int R = CIC_R;
`ifdef CIC_ROUND_EN
  localparam int FIRST = R + N + 1;
`else
  localparam int FIRST = R + N;
`endif

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   edge_k;

  logic signed [W-1:0] acc [6];
  logic signed [W-1:0] xin;
  bit                  integ_on;

  cic_decim_comb_if #(.W(W)) bus ();

  cic_decim_comb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output after the optional rounding stage (SH = 28).
  function automatic logic signed [W-1:0] exp_out(input logic signed [W-1:0] v);
`ifdef CIC_ROUND_EN
    logic signed [W-1:0] s;
    s = v + 44'sh000_0800_0000;
    return s >>> 28;
`else
    return v;
`endif
  endfunction

  // One posedge, then settle at the negedge where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    edge_k++;
    @(negedge clk);
    if (integ_on) begin
      acc[0] = acc[0] + xin;
      for (int i = 1; i < 6; i++) acc[i] = acc[i] + acc[i-1];
      bus.Intin = acc[5];
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
    edge_k = 0;
    for (int i = 0; i < 6; i++) acc[i] = '0;
  endtask

  task automatic test_reset();
    bus.Intin = 44'h123;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared += 2;
      if (bus.Dout !== '0) begin
        mismatched++;
        $display("FAIL reset_dout cycle %0d: got %h want 0", i, bus.Dout);
      end
      if (bus.Dvalid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_dvalid cycle %0d: got %b want 0", i, bus.Dvalid);
      end
    end
    rst = 1'b1;
    edge_k = 0;
    tick();
    compared += 2;
    if (bus.Dout !== '0) begin
      mismatched++;
      $display("FAIL post_reset_dout: got %h want 0", bus.Dout);
    end
    if (bus.Dvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_dvalid: got %b want 0", bus.Dvalid);
    end
  endtask

  // Continues straight from test_reset: pulses only after edges FIRST + m*R.
  task automatic test_timing();
    logic want;
    while (edge_k < 1000) begin
      tick();
      want = (edge_k >= FIRST) && (((edge_k - FIRST) % R) == 0);
      compared++;
      if (bus.Dvalid !== want) begin
        mismatched++;
        $display("FAIL timing edge %0d: got dvalid %b want %b", edge_k, bus.Dvalid, want);
      end
    end
  endtask

  task automatic test_constant();
    logic signed [W-1:0] exp_v [8];
    exp_v = '{44'sd100, -44'sd500, 44'sd1000, -44'sd1000, 44'sd500, -44'sd100, 44'sd0, 44'sd0};
    apply_reset(1);
    bus.Intin = 44'sd100;
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < R + 8 && !(bus.Dvalid === 1'b1 && edge_k > 0); t++) tick();
      compared += 2;
      if (bus.Dvalid !== 1'b1) begin
        mismatched++;
        $display("FAIL const_timeout out %0d: got no dvalid want pulse", k);
      end
      if (edge_k != FIRST + k * R) begin
        mismatched++;
        $display("FAIL const_edge out %0d: got edge %0d want %0d", k, edge_k, FIRST + k * R);
      end
      compared++;
      if (bus.Dout !== exp_out(exp_v[k])) begin
        mismatched++;
        $display("FAIL const_dout out %0d: got %0d want %0d", k, bus.Dout, exp_out(exp_v[k]));
      end
      tick();
    end
  endtask

  task automatic test_full_cic(input logic signed [W-1:0] x, input logic signed [W-1:0] steady);
    apply_reset(1);
    xin = x;
    bus.Intin = '0;
    integ_on = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int t = 0; t < R + 8 && !(bus.Dvalid === 1'b1); t++) tick();
      compared++;
      if (bus.Dvalid !== 1'b1) begin
        mismatched++;
        $display("FAIL cic_timeout out %0d: got no dvalid want pulse", k);
      end
      if (k >= 6) begin
        compared++;
        if (bus.Dout !== steady) begin
          mismatched++;
          $display("FAIL cic_steady x=%0d out %0d: got %h want %h", x, k, bus.Dout, steady);
        end
      end
      tick();
    end
    integ_on = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic signed [W-1:0] exp_v [5];
    exp_v = '{44'sd100, -44'sd500, 44'sd1000, -44'sd1000, 44'sd500};
    apply_reset(1);
    bus.Intin = 44'sd100;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < R + 8 && !(bus.Dvalid === 1'b1 && edge_k > 0); t++) tick();
      compared++;
      if (bus.Dout !== exp_out(exp_v[k]) || bus.Dvalid !== 1'b1) begin
        mismatched++;
        $display("FAIL mid_pre out %0d: got %0d/%b want %0d/1", k, bus.Dout, bus.Dvalid, exp_out(exp_v[k]));
      end
      tick();
    end
    // Stop right before the edge at which the phase counter reads 60.
    while (edge_k % R != 60) tick();
    rst = 1'b0;
    tick();
    compared++;
    if (bus.Dvalid !== 1'b0 || bus.Dout !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_clear: got %h/%b want 0/0", bus.Dout, bus.Dvalid);
    end
    rst = 1'b1;
    edge_k = 0;
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < R + 8 && !(bus.Dvalid === 1'b1 && edge_k > 0); t++) tick();
      compared += 2;
      if (edge_k != FIRST + k * R) begin
        mismatched++;
        $display("FAIL mid_restart_edge out %0d: got edge %0d want %0d", k, edge_k, FIRST + k * R);
      end
      if (bus.Dout !== exp_out(exp_v[k])) begin
        mismatched++;
        $display("FAIL mid_restart_dout out %0d: got %0d want %0d", k, bus.Dout, exp_out(exp_v[k]));
      end
      tick();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    edge_k     = 0;
    integ_on   = 1'b0;
    xin        = '0;
    for (int i = 0; i < 6; i++) acc[i] = '0;
    rst        = 1'b0;
    bus.Intin  = '0;
    @(negedge clk);

    test_reset();
    test_timing();
    test_constant();
`ifdef CIC_ROUND_EN
    test_full_cic(44'sd1, 44'sd16384);
    test_full_cic(-44'sd1, -44'sd16384);
`else
    test_full_cic(44'sd1, 44'sh400_0000_0000);
    test_full_cic(-44'sd1, -44'sh400_0000_0000);
`endif
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
